// File: rtl/field_packer_pkg.sv
// field_packer_pkg: shared types and constants for the nibble-to-frame packer.
package field_packer_pkg;

   localparam int NIB_W = 4;

   typedef enum bit [1:0] {
      S_IDLE,
      S_FILL,
      S_HOLD
   } state_e;

   typedef struct packed {
      bit       short_frame;
      bit [5:0] count;
   } frame_info_t;

endpackage

// File: rtl/field_packer_if.sv
// field_packer_if: upstream nibble stream plus downstream frame handshake.
// The packer uses the slave view; whoever feeds and drains it uses master.
interface field_packer_if #(
   parameter int NIBBLES = 42
);
   import field_packer_pkg::*;

   logic                             in_valid;
   logic [NIB_W-1:0]                 in_data;
   logic                             in_last;
   logic                             in_ready;
   logic                             out_valid;
   logic [NIBBLES-1:0][NIB_W-1:0]    out_data;
   frame_info_t                      out_info;
   logic                             out_ready;
   state_e                           state;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_info, state
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_info, state
   );

endinterface

// File: rtl/field_packer_nib_counter.sv
// nib_counter: counts nibbles accepted into the current frame and flags
// when the next accepted nibble will be the last slot of a full frame.
module nib_counter #(
   parameter int LIMIT = 42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_inc,
   input  logic       i_clear,
   output logic [5:0] o_count,
   output logic       o_atLimit
);

   localparam logic [5:0] LAST_SLOT = 6'(LIMIT - 1);

   logic [5:0] r_count;

   // Frame count: cleared when the held frame leaves, bumped on each accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + 6'd1;
      end
   end

   assign o_count   = r_count;
   assign o_atLimit = (r_count == LAST_SLOT);

endmodule

// File: rtl/field_packer.sv
// field_packer: gathers up to NIBBLES 4-bit elements into one wide frame,
// ending early on in_last, and holds the frame until downstream takes it.
// NIBBLES must lie in 1..63 so the frame count fits six bits.
module field_packer
   import field_packer_pkg::*;
#(
   parameter int NIBBLES = 42
) (
   input logic           clk,
   input logic           rst_n,
   field_packer_if.slave bus
);

   state_e                        r_state;
   state_e                        w_nextState;
   logic [NIBBLES-1:0][NIB_W-1:0] r_data;
   frame_info_t                   r_info;

   logic       w_inReady;
   logic       w_accept;
   logic       w_final;
   logic       w_release;
   logic [5:0] w_count;
   logic       w_atLimit;

   assign w_inReady = (r_state != S_HOLD);
   assign w_accept  = bus.in_valid && w_inReady;
   assign w_final   = w_accept && (w_atLimit || bus.in_last);
   assign w_release = (r_state == S_HOLD) && bus.out_ready;

   nib_counter #(
      .LIMIT(NIBBLES)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_inc    (w_accept),
      .i_clear  (w_release),
      .o_count  (w_count),
      .o_atLimit(w_atLimit)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: a completing nibble jumps straight to HOLD, even from IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_final) begin
               w_nextState = S_HOLD;
            end else if (w_accept) begin
               w_nextState = S_FILL;
            end
         end
         S_FILL: begin
            if (w_final) begin
               w_nextState = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Frame storage: the k-th accepted nibble lands in slot k; emptied on release
   // so unwritten slots of the next short frame read back as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (w_release) begin
         r_data <= '0;
      end else begin
         for (int k = 0; k < NIBBLES; k++) begin
            if (w_accept && (w_count == 6'(k))) begin
               r_data[k] <= bus.in_data;
            end
         end
      end
   end

   // Frame info captured on the completing accept: count includes that nibble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_info <= '0;
      end else if (w_release) begin
         r_info <= '0;
      end else if (w_final) begin
         r_info.short_frame <= !w_atLimit;
         r_info.count       <= w_count + 6'd1;
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = (r_state == S_HOLD);
   assign bus.out_data  = r_data;
   assign bus.out_info  = r_info;
   assign bus.state     = r_state;

endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: directed scenarios for the packer with a scoreboard of
// expected frames, plus a single-nibble instance.
module tb_field_packer;
   import field_packer_pkg::*;

   localparam int NIB = 42;
   localparam int W   = NIB * NIB_W;

   typedef struct {
      logic [W-1:0] data;
      logic [6:0]   info;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   testsRun  = 0;
   int   failCount = 0;
   exp_t sbQueue[$];

   field_packer_if #(.NIBBLES(NIB)) bus ();
   field_packer_if #(.NIBBLES(1))   bus1 ();

   field_packer #(.NIBBLES(NIB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   field_packer #(.NIBBLES(1)) dut1 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus1)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Safety net in case the run wedges somewhere unexpected.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents one nibble and returns at the negedge after it was taken.
   task automatic sendNibble(input logic [3:0] d, input logic l);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         checkOutput("accept timeout", W'(bus.in_ready), W'(1));
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Sends one frame; mode 0 = k mod 10, 1 = all 0xA, 2 = random nibbles.
   task automatic applyStimulus(input int len, input bit useLast, input int mode);
      exp_t        e;
      logic [3:0]  nib;
      e.data = '0;
      for (int k = 0; k < len; k++) begin
         if (mode == 0)      nib = 4'(k % 10);
         else if (mode == 1) nib = 4'hA;
         else                nib = 4'($urandom_range(0, 15));
         e.data[k*4 +: 4] = nib;
      end
      e.info = {(len < NIB) ? 1'b1 : 1'b0, 6'(len)};
      sbQueue.push_back(e);
      for (int k = 0; k < len; k++) begin
         sendNibble(e.data[k*4 +: 4], useLast && (k == len - 1));
      end
      checkOutput("latency out_valid", W'(bus.out_valid), W'(1));
   endtask

   // Compares the held frame with the scoreboard, optionally watching it leave.
   task automatic checkFrame(input bit expectRelease);
      exp_t e;
      e = sbQueue.pop_front();
      checkOutput("hold state", W'(bus.state), W'(S_HOLD));
      checkOutput("hold in_ready", W'(bus.in_ready), W'(0));
      checkOutput("frame data", W'(bus.out_data), e.data);
      checkOutput("frame info", W'(bus.out_info), W'(e.info));
      if (expectRelease) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("release state", W'(bus.state), W'(S_IDLE));
         checkOutput("release out_valid", W'(bus.out_valid), W'(0));
         checkOutput("release data", W'(bus.out_data), W'(0));
         checkOutput("release info", W'(bus.out_info), W'(0));
      end
   endtask

   initial begin
      logic [3:0] d;

      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.in_last   = 1'b0;
      bus1.out_ready = 1'b0;

      // Reset values, before any clock edge.
      #3;
      checkOutput("reset state", W'(bus.state), W'(S_IDLE));
      checkOutput("reset out_valid", W'(bus.out_valid), W'(0));
      checkOutput("reset out_data", W'(bus.out_data), W'(0));
      checkOutput("reset out_info", W'(bus.out_info), W'(0));
      checkOutput("reset in_ready", W'(bus.in_ready), W'(1));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full frame, digits 0..9 repeating.
      bus.out_ready = 1'b1;
      applyStimulus(NIB, 1'b0, 0);
      checkFrame(1'b1);

      // Short frame of five 0xA nibbles.
      applyStimulus(5, 1'b1, 1);
      checkFrame(1'b1);

      // in_last on the final slot still counts as a full frame.
      applyStimulus(NIB, 1'b1, 2);
      checkFrame(1'b1);

      // Backpressure: frame held for ten cycles while upstream keeps offering.
      bus.out_ready = 1'b0;
      applyStimulus(7, 1'b1, 2);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'h5;
      bus.in_last  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("bp data stable", W'(bus.out_data), sbQueue[0].data);
         checkOutput("bp in_ready", W'(bus.in_ready), W'(0));
         checkOutput("bp state", W'(bus.state), W'(S_HOLD));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checkFrame(1'b1);
      applyStimulus(3, 1'b1, 2);
      checkFrame(1'b1);

      // Reset in the middle of a frame.
      for (int k = 0; k < 20; k++) begin
         sendNibble(4'(k + 1), 1'b0);
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midreset state", W'(bus.state), W'(S_IDLE));
      checkOutput("midreset out_valid", W'(bus.out_valid), W'(0));
      checkOutput("midreset out_data", W'(bus.out_data), W'(0));
      checkOutput("midreset out_info", W'(bus.out_info), W'(0));
      checkOutput("midreset in_ready", W'(bus.in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(4, 1'b1, 2);
      checkFrame(1'b1);

      // Single-nibble frames: IDLE straight to HOLD on every accept.
      bus1.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = 4'($urandom_range(1, 15));
         checkOutput("n1 idle", W'(bus1.state), W'(S_IDLE));
         bus1.in_valid = 1'b1;
         bus1.in_data  = d;
         bus1.in_last  = (i == 1);
         @(posedge clk);
         @(negedge clk);
         bus1.in_valid = 1'b0;
         checkOutput("n1 hold", W'(bus1.state), W'(S_HOLD));
         checkOutput("n1 out_valid", W'(bus1.out_valid), W'(1));
         checkOutput("n1 data", W'(bus1.out_data), W'(d));
         checkOutput("n1 info", W'(bus1.out_info), W'(7'h01));
         @(posedge clk);
         @(negedge clk);
         checkOutput("n1 release", W'(bus1.out_valid), W'(0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/field_packer.md
FIELD_PACKER -- requirements
Module: field_packer

Interface
REQ-001 Parameter NIBBLES, default 42, SHALL give the number of 4-bit elements per frame; legal range 1..63.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port in_valid  input  1  SHALL mean upstream nibble present.
REQ-005 Port in_data  input  4  SHALL carry the nibble.
REQ-006 Port in_last  input  1  SHALL mark the final nibble of a short frame.
REQ-007 Port in_ready  output  1  SHALL mean the block accepts a nibble this cycle.
REQ-008 Port out_valid  output  1  SHALL mean a packed frame is presented.
REQ-009 Port out_data  output  NIBBLES x 4 (packed bit [NIBBLES-1:0][3:0])  SHALL carry the frame.
REQ-010 Port out_info  output  frame_info_t (7)  SHALL carry {short_frame, count[5:0]}.
REQ-011 Port out_ready  input  1  SHALL mean downstream consumes the frame.
REQ-012 Port state  output  state_e (2)  SHALL expose the FSM state.

Function
REQ-013 FSM states SHALL be S_IDLE, S_FILL and S_HOLD.
REQ-014 in_ready SHALL be 1 in S_IDLE and S_FILL and 0 in S_HOLD.
REQ-015 A nibble is accepted when in_valid and in_ready are both 1; the k-th accepted nibble of a frame (k from 0) SHALL be written to out_data[k].
REQ-016 S_IDLE transitions:
  - Accepting a nibble SHALL move the FSM to S_FILL with count 1.
  - If that nibble completes the frame (NIBBLES==1 or in_last), the FSM SHALL go directly to S_HOLD.
REQ-017 In S_FILL, count SHALL increment on each accept.
REQ-018 The FSM SHALL go from S_FILL to S_HOLD on accepting the NIBBLES-th nibble or any nibble with in_last=1.
REQ-019 In_last on the NIBBLES-th nibble SHALL be treated as a full frame.
REQ-020 out_valid SHALL be 1 exactly while in S_HOLD.
REQ-021 out_valid SHALL rise on the cycle after the final accept; latency is 1 cycle.
REQ-022 In S_HOLD, out_data and out_info SHALL remain stable until out_ready=1.
REQ-023 An out_ready=1 cycle in S_HOLD SHALL move the FSM to S_IDLE; out_valid SHALL be 0 on the next cycle, and out_data, out_info and count SHALL clear to 0.
REQ-024 Nibble positions not written in a short frame SHALL read as 0.
REQ-025 out_info.count SHALL equal the number of nibbles in the frame (1..NIBBLES).
REQ-026 out_info.short_frame SHALL be 1 iff count < NIBBLES.
REQ-027 out_ready outside S_HOLD SHALL be ignored.
REQ-028 in_valid with in_ready=0 SHALL not be consumed; upstream holds the nibble.
REQ-029 Sustained throughput SHALL be one frame per NIBBLES+1 cycles when out_ready is held at 1.

Reset
REQ-030 While rst_n=0, and regardless of clk, the block SHALL hold:
  - state = S_IDLE
  - out_valid = 0
  - out_data = 0
  - out_info = 0
  - count = 0
  - in_ready = 1 (combinational from S_IDLE)
REQ-031 Reset asserted mid-frame or in S_HOLD SHALL discard the partial or held frame with no output handshake.

Structure
REQ-032 Package field_packer_pkg SHALL define:
  - state_e (enum bit [1:0] {S_IDLE, S_FILL, S_HOLD})
  - frame_info_t (struct packed {bit short_frame; bit [5:0] count;})
  - constant NIB_W = 4
REQ-033 One sub-module, nib_counter, SHALL hold the frame count and produce the full/at-limit flag (parameter LIMIT).

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
  - Full frame: NIBBLES=42, nibbles 0x0..0x9 repeating, in_last=0, out_ready=1. Required response: out_valid 1 cycle after the 42nd accept; out_data[k] = k mod 10; out_info = {0, 42}; in_ready=0 during S_HOLD.
  - Short frame: 5 nibbles 0xA with in_last on the 5th. Required response: out_data[4:0] = 0xA, upper 37 nibbles 0; out_info = {1, 5}.
  - Backpressure: out_ready=0 for 10 cycles in S_HOLD with in_valid=1. Required response: out_data stable, no nibble consumed; frame released on the first out_ready=1; S_IDLE next cycle.
  - in_last on the 42nd nibble. Required response: out_info = {0, 42}.
  - Reset mid-frame: rst_n low after 20 accepts. Required response: outputs and state 0 immediately; the next frame starts at out_data[0].
  - NIBBLES=1: every accept goes S_IDLE -> S_HOLD; out_info = {0, 1}.
